arcade_input_mapper: RTL
========================

# arcade_input_mapper

Parametrised player-input front end for arcade cores: decodes the `ps2_key` event stream into per-player key state, merges it with HPS joysticks, applies screen-orientation remapping and produces registered per-player direction, fire, start and timed coin-pulse outputs. Sits between `hps_io` and the game core in `emu`, replacing hand-written key and joystick glue. Supports up to four players, four rotations, an optional joystick merge mode and coin pulse stretching.

## Interface
- `PLAYERS`, 2: number of players, 1..4.
- `COIN_PULSE`, 1200000: coin output high time in `clk_sys` cycles (100 ms at 12 MHz); must be ≥1.
- `AF_HALF`, 600000: autofire half-period in cycles; used only with `AUTOFIRE_EN`.

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  `[10]` toggles per event, `[9]` 1=press, `[8]` extended, `[7:0]` scancode.
- `joystick`  in  16*PLAYERS  player p at `[16p+15:16p]`: bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
- `rotate`  in  2  0 none, 1 cw90, 2 180, 3 ccw90.
- `merge`  in  1  1: OR of all joysticks drives every player.
- `af_en`  in  PLAYERS  per-player autofire enable (present only with `AUTOFIRE_EN`).
- `up`, `down`, `left`, `right`, `fire`  out  PLAYERS each  mapped controls.
- `start`  out  2  start1/start2, OR over all players.
- `coin`  out  PLAYERS  stretched coin pulse per slot.

## Operation
- Event detect: registers `old_tog` and `primed`. First cycle after reset only captures `ps2_key[10]` and sets `primed`; no event is decoded. Afterwards `ps2_key[10] != old_tog` is one event, and the key register is set to `ps2_key[9]`.
- Keymap for player 0: E0-75/72/6B/74 map to up/down/left/right. 0x29 (space), 0x14 and E0-14 (ctrl) map to fire. 0x05 (F1) maps to start1 and 0x06 (F2) to start2. 0x2E ('5') maps to coin.
- Keymap for player 1 (if `PLAYERS`≥2): 0x2D R up, 0x2B F down, 0x23 D left, 0x34 G right, 0x1C A fire, 0x36 ('6') coin.
- Unlisted codes are ignored. Players 2–3 have no keys.
- Raw player p is keys(p) OR joystick(p), or OR of all joysticks when `merge`=1.
- Rotation, applied to directions only, output ← raw source:
  - rot1: up←left, down←right, left←down, right←up.
  - rot2: up←down, down←up, left←right, right←left.
  - rot3: up←right, down←left, left←up, right←down.
- Coin FSM per player has states IDLE, PULSE and HOLD.
  - IDLE: a rising request loads the counter with `COIN_PULSE-1` and moves to PULSE.
  - PULSE: `coin`=1 and the counter decrements; at 0 the FSM goes to HOLD if the request is still high, otherwise IDLE.
  - HOLD: waits for the request to drop, then goes to IDLE.
  - Requests during PULSE or HOLD are ignored.
- All counters are `$clog2` sized and never wrap. Start does not generate coin.

## Timing
- Reset: all outputs 0. Key registers, FSMs (IDLE), counters and `primed` are cleared.
- Joystick, `merge` and `rotate` reach the outputs 1 cycle after they change, with no combinational paths to the outputs.
- ps2 event: key register updates at the edge that sees the toggle; the output follows 1 edge later, 2 cycles in total.
- Simultaneous keyboard release and joystick hold: the output stays 1 (OR).
- Reset asserted mid-pulse: `coin` drops immediately.

## Configuration
- Macro `ARCADE_INPUT_AUTOFIRE_EN` compiles the autofire feature in or out.
- Defined:
  - The `af_en` port exists.
  - When `af_en[p]`=1 and raw fire is held, `fire[p]` is 1 for `AF_HALF` cycles, then 0 for `AF_HALF` cycles, repeating. The pattern starts high 1 cycle after press.
  - Release forces 0 and resets the phase counter.
- Undefined: no `af_en` port and no counter; `fire` = registered raw fire.

## Test plan
- Reset, then hold `joystick[3]`=1 with `rotate`=0 → `up[0]`=1 exactly 1 cycle later. With `rotate`=1 → `right[0]`=1, `up[0]`=0.
- Event E0-75 press (toggle flip, `[9]`=1) → `up[0]`=1 two cycles later. Release event → `up[0]`=0 two cycles after release.
- `ps2_key[10]`=1 held through reset release → no output change on the first cycle. A later flip is decoded normally.
- `COIN_PULSE`=8; hold 0x2E press for 20 cycles → `coin[0]` high exactly 8 cycles, then stays 0 until release and re-press. Reset at pulse cycle 3 → `coin[0]`=0 immediately.
- `merge`=1, `joystick[16+4]`=1 → `fire[0]` and `fire[1]` both 1. `merge`=0 → only `fire[1]`.
- With the macro, `AF_HALF`=4, `af_en[0]`=1, fire held 16 cycles → `fire[0]` pattern 1111000011110000. Without the macro → constant 1.

Source files
------------

// File: rtl/arcade_input_mapper_if.sv
// rtl/arcade_input_mapper_if.sv - player-input bus between hps_io glue and arcade_input_mapper
//
// Purpose: bundles the keyboard/joystick inputs and the mapped per-player
// control outputs of arcade_input_mapper into one interface.
// Signals:
//   ps2_key   [10] event toggle, [9] 1=press, [8] extended, [7:0] scancode
//   joystick  16 bits per player: 0 right, 1 left, 2 down, 3 up, 4 fire,
//             5 start1, 6 start2, 7 coin
//   rotate    0 none, 1 cw90, 2 180, 3 ccw90
//   merge     1: OR of all joysticks drives every player
//   af_en     per-player autofire enable (only with ARCADE_INPUT_AUTOFIRE_EN)
//   up/down/left/right/fire/coin  per-player mapped outputs
//   start     start1/start2, OR over all players
// Modports: master drives the inputs, slave is the mapper.
// Macro: ARCADE_INPUT_AUTOFIRE_EN adds af_en.

interface arcade_input_mapper_if #(
   parameter int PLAYERS = 2
);
   logic [10:0]            ps2_key;
   logic [16*PLAYERS-1:0]  joystick;
   logic [1:0]             rotate;
   logic                   merge;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   logic [PLAYERS-1:0]     af_en;
`endif
   logic [PLAYERS-1:0]     up;
   logic [PLAYERS-1:0]     down;
   logic [PLAYERS-1:0]     left;
   logic [PLAYERS-1:0]     right;
   logic [PLAYERS-1:0]     fire;
   logic [1:0]             start;
   logic [PLAYERS-1:0]     coin;

   modport master (
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      output af_en,
`endif
      output ps2_key, joystick, rotate, merge,
      input  up, down, left, right, fire, start, coin
   );

   modport slave (
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      input  af_en,
`endif
      input  ps2_key, joystick, rotate, merge,
      output up, down, left, right, fire, start, coin
   );
endinterface

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - keyboard/joystick to per-player arcade controls
//
// Purpose: decodes ps2_key events into per-player key state, ORs it with the
// HPS joysticks (or with the merged joystick), rotates directions for screen
// orientation and registers direction/fire/start outputs. Coin requests go
// through a per-player IDLE/PULSE/HOLD FSM that emits a COIN_PULSE-cycle pulse.
// Ports:
//   clk_sys  system clock, rising edge
//   reset    asynchronous, active-high
//   bus      arcade_input_mapper_if.slave (inputs ps2_key/joystick/rotate/
//            merge[/af_en], outputs up/down/left/right/fire/start/coin)
// Macro: ARCADE_INPUT_AUTOFIRE_EN enables per-player autofire (AF_HALF cycles
// high, AF_HALF cycles low while fire is held and af_en is set).

module arcade_input_mapper #(
   parameter int PLAYERS    = 2,
   parameter int COIN_PULSE = 1200000,
   parameter int AF_HALF    = 600000
) (
   input logic                  clk_sys,
   input logic                  reset,
   arcade_input_mapper_if.slave bus
);
   localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
   localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE - 1);

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_t;

   // Key bit layout matches the low byte of a joystick word.
   function automatic logic [7:0] key_mask(input int p, input logic [8:0] c);
      logic [7:0] m;
      m = '0;
      if (p == 0) begin
         case (c)
            9'h175:                m = 8'h08;
            9'h172:                m = 8'h04;
            9'h16B:                m = 8'h02;
            9'h174:                m = 8'h01;
            9'h029, 9'h014, 9'h114: m = 8'h10;
            9'h005:                m = 8'h20;
            9'h006:                m = 8'h40;
            9'h02E:                m = 8'h80;
            default:               m = '0;
         endcase
      end else if (p == 1) begin
         case (c)
            9'h02D:  m = 8'h08;
            9'h02B:  m = 8'h04;
            9'h023:  m = 8'h02;
            9'h034:  m = 8'h01;
            9'h01C:  m = 8'h10;
            9'h036:  m = 8'h80;
            default: m = '0;
         endcase
      end
      return m;
   endfunction

   logic       old_tog, primed, ps2_event;
   logic [7:0] keys [PLAYERS];

   // The first cycle after reset only learns the toggle level, so a toggle
   // bit left high across reset is not mistaken for an event.
   assign ps2_event = primed && (bus.ps2_key[10] != old_tog);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         old_tog <= 1'b0;
         primed  <= 1'b0;
         for (int p = 0; p < PLAYERS; p++) keys[p] <= '0;
      end else begin
         old_tog <= bus.ps2_key[10];
         primed  <= 1'b1;
         if (ps2_event)
            for (int p = 0; p < PLAYERS; p++)
               keys[p] <= (keys[p] & ~key_mask(p, bus.ps2_key[8:0]))
                        | ({8{bus.ps2_key[9]}} & key_mask(p, bus.ps2_key[8:0]));
      end
   end

   logic [7:0]         joy_or;
   logic [7:0]         raw [PLAYERS];
   logic [PLAYERS-1:0] up_n, down_n, left_n, right_n, fire_n, req;
   logic [1:0]         start_n;

   always_comb begin
      joy_or  = '0;
      start_n = '0;
      up_n    = '0;
      down_n  = '0;
      left_n  = '0;
      right_n = '0;
      req     = '0;
      for (int p = 0; p < PLAYERS; p++) joy_or |= bus.joystick[16*p +: 8];
      for (int p = 0; p < PLAYERS; p++) begin
         raw[p] = keys[p] | (bus.merge ? joy_or : bus.joystick[16*p +: 8]);
         start_n |= raw[p][6:5];
         req[p]   = raw[p][7];
         // raw bits: 0 right, 1 left, 2 down, 3 up
         case (bus.rotate)
            2'd1:    {up_n[p], down_n[p], left_n[p], right_n[p]} = {raw[p][1], raw[p][0], raw[p][2], raw[p][3]};
            2'd2:    {up_n[p], down_n[p], left_n[p], right_n[p]} = {raw[p][2], raw[p][3], raw[p][0], raw[p][1]};
            2'd3:    {up_n[p], down_n[p], left_n[p], right_n[p]} = {raw[p][0], raw[p][1], raw[p][3], raw[p][2]};
            default: {up_n[p], down_n[p], left_n[p], right_n[p]} = {raw[p][3], raw[p][2], raw[p][1], raw[p][0]};
         endcase
      end
   end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int AW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
   logic [AW-1:0]      af_cnt [PLAYERS];
   logic [PLAYERS-1:0] af_ph;

   // Phase 0 is the high half; the counter restarts on every release so the
   // pattern always begins high.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         af_ph <= '0;
         for (int p = 0; p < PLAYERS; p++) af_cnt[p] <= '0;
      end else begin
         for (int p = 0; p < PLAYERS; p++) begin
            if (!raw[p][4]) begin
               af_cnt[p] <= '0;
               af_ph[p]  <= 1'b0;
            end else if (af_cnt[p] == AW'(AF_HALF - 1)) begin
               af_cnt[p] <= '0;
               af_ph[p]  <= ~af_ph[p];
            end else begin
               af_cnt[p] <= af_cnt[p] + 1'b1;
            end
         end
      end
   end

   always_comb
      for (int p = 0; p < PLAYERS; p++) fire_n[p] = raw[p][4] & ~(bus.af_en[p] & af_ph[p]);
`else
   always_comb
      for (int p = 0; p < PLAYERS; p++) fire_n[p] = raw[p][4];
`endif

   logic [PLAYERS-1:0] up_q, down_q, left_q, right_q, fire_q;
   logic [1:0]         start_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         {up_q, down_q, left_q, right_q, fire_q} <= '0;
         start_q <= '0;
      end else begin
         up_q    <= up_n;
         down_q  <= down_n;
         left_q  <= left_n;
         right_q <= right_n;
         fire_q  <= fire_n;
         start_q <= start_n;
      end
   end

   // Coin FSM: state register, next-state logic, output decode.
   coin_state_t        cs [PLAYERS];
   coin_state_t        ns [PLAYERS];
   logic [CW-1:0]      cnt [PLAYERS];
   logic [CW-1:0]      cnt_n [PLAYERS];
   logic [PLAYERS-1:0] req_d, coin_o;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         req_d <= '0;
         for (int p = 0; p < PLAYERS; p++) begin
            cs[p]  <= IDLE;
            cnt[p] <= '0;
         end
      end else begin
         req_d <= req;
         for (int p = 0; p < PLAYERS; p++) begin
            cs[p]  <= ns[p];
            cnt[p] <= cnt_n[p];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         ns[p]    = cs[p];
         cnt_n[p] = cnt[p];
         case (cs[p])
            IDLE:
               if (req[p] && !req_d[p]) begin
                  ns[p]    = PULSE;
                  cnt_n[p] = COIN_LOAD;
               end
            PULSE:
               if (cnt[p] == '0) ns[p] = req[p] ? HOLD : IDLE;
               else              cnt_n[p] = cnt[p] - 1'b1;
            HOLD:
               if (!req[p]) ns[p] = IDLE;
            default: ns[p] = IDLE;
         endcase
      end
   end

   // Decoded straight from the state register so reset clears it at once.
   always_comb
      for (int p = 0; p < PLAYERS; p++) coin_o[p] = (cs[p] == PULSE);

   assign bus.up    = up_q;
   assign bus.down  = down_q;
   assign bus.left  = left_q;
   assign bus.right = right_q;
   assign bus.fire  = fire_q;
   assign bus.start = start_q;
   assign bus.coin  = coin_o;
endmodule
